uart_transmitter: RTL and testbench

UART 8N1 serial transmitter using 16× oversampling. It is the transmit counterpart of the design's UART receiver and shares the same `baud_gen.tick` strobe as its bit-timing reference. Bytes come in over a valid/ready handshake into a small internal FIFO. They are serialised LSB-first on `tx`, with frames sent back-to-back while data is queued.

---
 rtl/uart_transmitter.sv | 166 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter timed by a shared 16x oversampling strobe, fed through a small FIFO.
// Frames are serialised LSB-first and sent back-to-back while bytes remain queued.
module uart_transmitter #(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned STOP_BIT_TICK = 16,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                             clk_50MHz,
  input  logic                             reset,
  input  logic                             sample_tick,
  input  logic [DATA_BITS-1:0]             tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             tx,
  output logic                             tx_busy,
  output logic                             tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned TickW = $clog2(STOP_BIT_TICK);
  localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(STOP_BIT_TICK - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;

  // Serialiser state
  state_e               state_q;
  logic [TickW-1:0]     tick_q;
  logic [BitW-1:0]      bit_q;
  logic [DATA_BITS-1:0] shift_q;

  logic                 push;
  logic                 pop;
  logic                 fifo_nonempty;
  logic                 tick_last;
  logic [DATA_BITS-1:0] fifo_head;
  logic [DATA_BITS-1:0] shift_next;

  always_comb begin
    fifo_count    = count_q;
    tx_ready      = (count_q != CntFull);
    fifo_nonempty = (count_q != '0);
    fifo_head     = fifo_mem_q[rd_ptr_q];
    tick_last     = (tick_q == TickLast);
    shift_next    = shift_q >> 1;
    push          = tx_valid && tx_ready;
    // A pop happens exactly where the FSM launches a frame: from idle, or at the end of a stop bit.
    pop           = sample_tick && fifo_nonempty &&
                    ((state_q == StIdle) || ((state_q == StStop) && tick_last));
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset && push) begin
      fifo_mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (sample_tick) begin
        unique case (state_q)
          StIdle: begin
            if (fifo_nonempty) begin
              shift_q <= fifo_head;
              tx      <= 1'b0;
              tick_q  <= '0;
              tx_busy <= 1'b1;
              state_q <= StStart;
            end
          end
          StStart: begin
            if (tick_last) begin
              tick_q  <= '0;
              bit_q   <= '0;
              tx      <= shift_q[0];
              state_q <= StData;
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
          StData: begin
            if (tick_last) begin
              tick_q <= '0;
              if (bit_q == BitLast) begin
                tx      <= 1'b1;
                state_q <= StStop;
              end else begin
                shift_q <= shift_next;
                tx      <= shift_next[0];
                bit_q   <= bit_q + BitW'(1);
              end
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
          StStop: begin
            if (tick_last) begin
              tick_q  <= '0;
              tx_done <= 1'b1;
              // Chain straight into the next start bit so queued frames leave no idle gap.
              if (fifo_nonempty) begin
                shift_q <= fifo_head;
                tx      <= 1'b0;
                state_q <= StStart;
              end else begin
                tx_busy <= 1'b0;
                state_q <= StIdle;
              end
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assert property (@(posedge clk_50MHz) disable iff (reset) count_q <= CntFull);

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: random bytes and tick rates, with a line-level frame decoder
// acting as the reference receiver and plain queues holding the expected byte order.
module tb_uart_transmitter;

  localparam int DATA_BITS     = 8;
  localparam int STOP_BIT_TICK = 16;
  localparam int FIFO_DEPTH    = 4;
  localparam int FRAME_TICKS   = (DATA_BITS + 2) * STOP_BIT_TICK;
  localparam int PUSH_BOUND    = 20000;

  logic       clk_50MHz;
  logic       reset;
  logic       sample_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  uart_transmitter #(
    .DATA_BITS    (DATA_BITS),
    .STOP_BIT_TICK(STOP_BIT_TICK),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .reset      (reset),
    .sample_tick(sample_tick),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int push_timeouts = 0;

  // Tick source
  bit tick_en = 0;
  int tick_period = 27;
  int tick_cnt = 0;

  // Reference receiver / monitor state
  logic [7:0] rx_q[$];
  int         frame_starts[$];
  int         done_ticks[$];
  int         cnt_hist[$];
  int         done_cnt, done_double, frame_err, busy_ticks, tick_idx, max_count, last_cnt;
  bit         in_frame;
  int         nsamp;
  logic       samp [FRAME_TICKS];
  bit         pend_tick, pend_reset, edge_tick, edge_reset, busy_prev, prev_done, frame_ok;
  logic [7:0] byte_v;

  initial begin
    clk_50MHz = 1'b0;
    forever #10 clk_50MHz = ~clk_50MHz;
  end

  initial begin
    sample_tick = 1'b0;
    forever begin
      @(posedge clk_50MHz);
      #1;
      if (tick_en) begin
        if (tick_cnt >= tick_period - 1) begin
          sample_tick = 1'b1;
          tick_cnt = 0;
        end else begin
          sample_tick = 1'b0;
          tick_cnt++;
        end
      end
    end
  end

  // Inputs change just after posedge, so values seen at a negedge are those the next posedge samples.
  initial begin
    pend_tick = 0; pend_reset = 0; busy_prev = 0; prev_done = 0; in_frame = 0; nsamp = 0;
    tick_idx = 0; done_cnt = 0; done_double = 0; frame_err = 0; busy_ticks = 0;
    max_count = 0; last_cnt = 0;
    forever begin
      @(negedge clk_50MHz);
      edge_tick  = pend_tick;
      edge_reset = pend_reset;
      pend_tick  = (sample_tick === 1'b1);
      pend_reset = (reset === 1'b1);
      if (edge_reset) begin
        in_frame  = 0;
        prev_done = 0;
      end else begin
        if (edge_tick) begin
          tick_idx++;
          if (busy_prev) busy_ticks++;
          if (!in_frame && tx === 1'b0) begin
            in_frame = 1;
            nsamp = 0;
            frame_starts.push_back(tick_idx);
          end
          if (in_frame) begin
            samp[nsamp] = tx;
            nsamp++;
            if (nsamp == FRAME_TICKS) begin
              frame_ok = (samp[0] === 1'b0) && (samp[FRAME_TICKS-1] === 1'b1);
              for (int w = 0; w < DATA_BITS + 2; w++)
                for (int j = 0; j < STOP_BIT_TICK; j++)
                  if (samp[w*STOP_BIT_TICK+j] !== samp[w*STOP_BIT_TICK]) frame_ok = 0;
              for (int b = 0; b < DATA_BITS; b++) byte_v[b] = samp[(b+1)*STOP_BIT_TICK];
              rx_q.push_back(byte_v);
              if (!frame_ok) frame_err++;
              in_frame = 0;
            end
          end
        end
        if (tx_done === 1'b1) begin
          done_cnt++;
          done_ticks.push_back(tick_idx);
          if (prev_done) done_double++;
        end
        prev_done = (tx_done === 1'b1);
      end
      busy_prev = (tx_busy === 1'b1);
      if (int'(fifo_count) != last_cnt) begin
        last_cnt = int'(fifo_count);
        cnt_hist.push_back(last_cnt);
      end
      if (last_cnt > max_count) max_count = last_cnt;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: got time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_mon();
    rx_q.delete(); frame_starts.delete(); done_ticks.delete(); cnt_hist.delete();
    done_cnt = 0; done_double = 0; frame_err = 0; busy_ticks = 0; max_count = 0;
    last_cnt = int'(fifo_count); push_timeouts = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_50MHz);
      #1;
    end
  endtask

  task automatic start_ticks(input int period);
    tick_period = period;
    tick_cnt = 0;
    tick_en = 1;
  endtask

  task automatic stop_ticks();
    tick_en = 0;
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tx_valid = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);
    clear_mon();
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit acc;
    acc = 0;
    tx_valid = 1'b1;
    tx_data = b;
    for (int i = 0; i < PUSH_BOUND && !acc; i++) begin
      acc = tx_ready;
      idle(1);
    end
    tx_valid = 1'b0;
    if (!acc) push_timeouts++;
  endtask

  task automatic wait_done(input int n, input int bound, output bit ok);
    ok = (done_cnt >= n);
    for (int i = 0; i < bound && !ok; i++) begin
      idle(1);
      if (done_cnt >= n) ok = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    start_ticks(3);
    idle(4);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", tx_done); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", tx_ready); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
    reset = 1'b0;
    idle(30);
    n_checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got tx=%b busy=%b required tx=1 busy=0", tx, tx_busy); end
    clear_mon();
  endtask

  task automatic test_single_byte();
    bit ok;
    do_reset();
    start_ticks(27);
    idle(5);
    push_byte(8'hA5);
    wait_done(1, FRAME_TICKS * 27 + 2000, ok);
    idle(27 * 4);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_done_timeout: got %0d done pulses required 1", done_cnt); end
    n_checks++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL single_frames: got %0d required 1", rx_q.size()); end
    n_checks++; if (rx_q.size() > 0 && rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_value: got %h required a5", rx_q[0]); end
    n_checks++; if (frame_err != 0) begin n_fail++; $display("FAIL single_framing: got %0d bad frames required 0", frame_err); end
    n_checks++; if (done_cnt != 1 || done_double != 0) begin n_fail++; $display("FAIL single_done_pulse: got %0d pulses (%0d long) required 1 (0)", done_cnt, done_double); end
    n_checks++; if (busy_ticks != FRAME_TICKS) begin n_fail++; $display("FAIL single_busy_ticks: got %0d required %0d", busy_ticks, FRAME_TICKS); end
    n_checks++;
    if (done_ticks.size() != 1 || frame_starts.size() != 1 || done_ticks[0] - frame_starts[0] != FRAME_TICKS) begin
      n_fail++; $display("FAIL single_done_timing: got %0d done, %0d starts required done 160 ticks after start", done_ticks.size(), frame_starts.size());
    end
    n_checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got tx=%b busy=%b required 1/0", tx, tx_busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int per;
    int exp_hist[4] = '{1, 2, 1, 0};
    do_reset();
    stop_ticks();
    idle(2);
    push_byte(8'h55);
    push_byte(8'h0F);
    per = int'($urandom_range(3, 8));
    start_ticks(per);
    wait_done(2, 2 * FRAME_TICKS * per + 2000, ok);
    idle(per * 20);
    n_checks++; if (!ok || done_cnt != 2) begin n_fail++; $display("FAIL b2b_done: got %0d pulses required 2", done_cnt); end
    n_checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h55 || rx_q[1] !== 8'h0F) begin
      n_fail++; $display("FAIL b2b_bytes: got %0d frames required 55,0f", rx_q.size());
    end
    n_checks++; if (frame_err != 0) begin n_fail++; $display("FAIL b2b_framing: got %0d bad frames required 0", frame_err); end
    n_checks++;
    if (frame_starts.size() != 2 || frame_starts[1] - frame_starts[0] != FRAME_TICKS) begin
      n_fail++; $display("FAIL b2b_gap: got %0d starts required 2 starts 160 ticks apart", frame_starts.size());
    end
    n_checks++;
    if (done_ticks.size() != 2 || done_ticks[1] - done_ticks[0] != FRAME_TICKS) begin
      n_fail++; $display("FAIL b2b_done_spacing: got %0d pulses required 2 pulses 160 ticks apart", done_ticks.size());
    end
    n_checks++; if (cnt_hist.size() != 4) begin n_fail++; $display("FAIL b2b_count_len: got %0d changes required 4", cnt_hist.size()); end
    for (int i = 0; i < 4 && i < cnt_hist.size(); i++) begin
      n_checks++; if (cnt_hist[i] != exp_hist[i]) begin n_fail++; $display("FAIL b2b_count_seq[%0d]: got %0d required %0d", i, cnt_hist[i], exp_hist[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok, dup;
    int per;
    logic [7:0] bp[6];
    logic [7:0] c;
    do_reset();
    stop_ticks();
    for (int i = 0; i < 6; i++) begin
      do begin
        c = 8'($urandom_range(0, 255));
        dup = 0;
        for (int j = 0; j < i; j++) if (bp[j] == c) dup = 1;
      end while (dup);
      bp[i] = c;
    end
    for (int i = 0; i < 4; i++) push_byte(bp[i]);
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b required 0", tx_ready); end
    tx_valid = 1'b1; tx_data = bp[4];
    idle(3);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_count_full: got %0d required 4", fifo_count); end
    per = int'($urandom_range(3, 8));
    start_ticks(per);
    push_byte(bp[4]);
    n_checks++; if (frame_starts.size() != 1) begin n_fail++; $display("FAIL bp_accept_after_pop: got %0d launches required 1", frame_starts.size()); end
    push_byte(bp[5]);
    wait_done(6, 6 * FRAME_TICKS * per + 4000, ok);
    idle(per * 20);
    n_checks++; if (!ok || push_timeouts != 0) begin n_fail++; $display("FAIL bp_timeout: got %0d done, %0d stuck pushes required 6, 0", done_cnt, push_timeouts); end
    n_checks++; if (rx_q.size() != 6) begin n_fail++; $display("FAIL bp_frames: got %0d required 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== bp[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h required %h", i, rx_q[i], bp[i]); end
    end
    n_checks++; if (frame_err != 0 || max_count != 4) begin n_fail++; $display("FAIL bp_integrity: got %0d bad frames, max count %0d required 0, 4", frame_err, max_count); end
  endtask

  task automatic test_tick_coincident();
    bit ok;
    int tick_w;
    logic [7:0] b;
    do_reset();
    stop_ticks();
    idle(3);
    b = 8'($urandom_range(0, 255));
    tx_valid = 1'b1; tx_data = b; sample_tick = 1'b1;
    idle(1);
    tx_valid = 1'b0; sample_tick = 1'b0;
    n_checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL coinc_no_launch: got tx=%b busy=%b required 1/0", tx, tx_busy); end
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL coinc_count: got %0d required 1", fifo_count); end
    @(negedge clk_50MHz);
    #1;
    tick_w = tick_idx;
    idle(3);
    sample_tick = 1'b1;
    idle(1);
    sample_tick = 1'b0;
    n_checks++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL coinc_launch: got tx=%b busy=%b required 0/1", tx, tx_busy); end
    start_ticks(4);
    wait_done(1, FRAME_TICKS * 4 + 1000, ok);
    n_checks++;
    if (!ok || frame_starts.size() != 1 || frame_starts[0] != tick_w + 1) begin
      n_fail++; $display("FAIL coinc_start_tick: got %0d starts (done=%0d) required start at tick %0d", frame_starts.size(), done_cnt, tick_w + 1);
    end
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== b) begin n_fail++; $display("FAIL coinc_value: got %0d frames required one frame of %h", rx_q.size(), b); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok, got;
    int per;
    do_reset();
    stop_ticks();
    push_byte(8'hC3);
    push_byte(8'($urandom_range(0, 255)));
    push_byte(8'($urandom_range(0, 255)));
    per = int'($urandom_range(3, 6));
    start_ticks(per);
    got = 0;
    for (int i = 0; i < FRAME_TICKS * per * 2 && !got; i++) begin
      idle(1);
      if (in_frame && nsamp >= 4 * STOP_BIT_TICK + 6) got = 1;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL rst_mid_reach: got nsamp=%0d required data bit 3 reached", nsamp); end
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rst_mid_bit3: got %b required 0", tx); end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    n_checks++; if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got tx=%b busy=%b done=%b required 1/0/0", tx, tx_busy, tx_done); end
    n_checks++; if (fifo_count !== 3'd0 || tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flush: got count=%0d ready=%b required 0/1", fifo_count, tx_ready); end
    idle(200 * per);
    n_checks++; if (done_cnt != 0 || frame_starts.size() != 1) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d done, %0d starts required 0, 1", done_cnt, frame_starts.size()); end
    clear_mon();
    push_byte(8'h81);
    wait_done(1, FRAME_TICKS * per + 2000, ok);
    n_checks++; if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'h81 || frame_err != 0) begin n_fail++; $display("FAIL rst_mid_resume: got %0d frames, %0d bad required one clean 81", rx_q.size(), frame_err); end
  endtask

  task automatic test_stream(input string name, input int n, input logic [7:0] fixed[3], input bit use_fixed);
    bit ok;
    int per;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    do_reset();
    per = int'($urandom_range(2, 8));
    start_ticks(per);
    for (int i = 0; i < n; i++) begin
      b = use_fixed ? fixed[i % 3] : 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      push_byte(b);
      idle(int'($urandom_range(0, 300)));
    end
    wait_done(n, n * FRAME_TICKS * per + 4000, ok);
    n_checks++; if (!ok || rx_q.size() != n) begin n_fail++; $display("FAIL %s_count: got %0d frames required %0d", name, rx_q.size(), n); end
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s_byte[%0d]: got %h required %h", name, i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (frame_err != 0 || done_double != 0) begin n_fail++; $display("FAIL %s_framing: got %0d bad, %0d long pulses required 0, 0", name, frame_err, done_double); end
  endtask

  initial begin
    logic [7:0] lb[3];
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_backpressure();
    test_tick_coincident();
    test_reset_mid_frame();
    test_stream("loopback", 3, lb, 1'b1);
    test_stream("random", 5, lb, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
